// File: rtl/ksa_pkg.sv
// Shared types and elaboration helpers for the gate-level pipelined
// Kogge-Stone adder/subtractor.
package ksa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Prefix level lvl (0-based) combines bit i with bit i - 2**lvl.
    function automatic int prefix_dist(input int lvl);
        return 1 << lvl;
    endfunction

endpackage

// File: rtl/ksa_prefix_stage.sv
// One registered Kogge-Stone prefix level; the original propagate,
// carry-in and valid ride alongside so every path is balanced.
module ksa_prefix_stage
    import ksa_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic             c_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out,
    output logic [WIDTH-1:0] x_out,
    output logic             c_out,
    output logic             v_out
);

    gp_t [WIDTH-1:0] nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_op
            assign nxt[i].g = g_in[i] | (p_in[i] & g_in[i-DIST]);
            assign nxt[i].p = p_in[i] & p_in[i-DIST];
        end else begin : g_pass
            assign nxt[i].g = g_in[i];
            assign nxt[i].p = p_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_out <= '0;
            p_out <= '0;
            x_out <= '0;
            c_out <= 1'b0;
            v_out <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                g_out[i] <= nxt[i].g;
                p_out[i] <= nxt[i].p;
            end
            x_out <= x_in;
            c_out <= c_in;
            v_out <= v_in;
        end
    end

endmodule

// File: rtl/ksa_pipe_addsub.sv
// Gate-level pipelined Kogge-Stone adder/subtractor: one operand pair
// per cycle, fixed latency of clog2(WIDTH)+2 edges, zero output when idle.
module ksa_pipe_addsub
    import ksa_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             GCLK_Pad,
    input  logic             rst_Pad,
    input  logic [WIDTH-1:0] a_Pad,
    input  logic [WIDTH-1:0] b_Pad,
    input  logic             cin_Pad,
    input  logic             sub_Pad,
    input  logic             vld_Pad,
    output logic [WIDTH-1:0] sum_Pad,
    output logic             cout_Pad,
    output logic             ovf_Pad,
    output logic             ovld_Pad
);

    localparam int LVL = clog2(WIDTH);
    localparam int LAT = LVL + 2;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;
    logic             v_r;

    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            a_r <= '0;
            b_r <= '0;
            c_r <= 1'b0;
            v_r <= 1'b0;
        end else begin
            a_r <= a_Pad;
            b_r <= b_Pad ^ {WIDTH{sub_Pad}};
            c_r <= sub_Pad | cin_Pad;
            v_r <= vld_Pad;
        end
    end

    gp_t [WIDTH-1:0] gp1;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            gp1[i].g = a_r[i] & b_r[i];
            gp1[i].p = a_r[i] ^ b_r[i];
        end
        gp1[0].g = (a_r[0] & b_r[0]) | ((a_r[0] ^ b_r[0]) & c_r);
    end

    logic [WIDTH-1:0] g1;
    logic [WIDTH-1:0] p1;
    logic             c1;
    logic             v1;

    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            g1 <= '0;
            p1 <= '0;
            c1 <= 1'b0;
            v1 <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                g1[i] <= gp1[i].g;
                p1[i] <= gp1[i].p;
            end
            c1 <= c_r;
            v1 <= v_r;
        end
    end

    // Index 0 is the g/p stage; index j+1 is the output of prefix level j.
    logic [LAT-2:0][WIDTH-1:0] g_s;
    logic [LAT-2:0][WIDTH-1:0] p_s;
    logic [LAT-2:0][WIDTH-1:0] x_s;
    logic [LAT-2:0]            c_s;
    logic [LAT-2:0]            v_s;

    assign g_s[0] = g1;
    assign p_s[0] = p1;
    assign x_s[0] = p1;
    assign c_s[0] = c1;
    assign v_s[0] = v1;

    for (genvar j = 0; j < LVL; j++) begin : g_lvl
        ksa_prefix_stage #(
            .WIDTH (WIDTH),
            .DIST  (prefix_dist(j))
        ) u_stage (
            .clk   (GCLK_Pad),
            .rst   (rst_Pad),
            .g_in  (g_s[j]),
            .p_in  (p_s[j]),
            .x_in  (x_s[j]),
            .c_in  (c_s[j]),
            .v_in  (v_s[j]),
            .g_out (g_s[j+1]),
            .p_out (p_s[j+1]),
            .x_out (x_s[j+1]),
            .c_out (c_s[j+1]),
            .v_out (v_s[j+1])
        );
    end

    logic [WIDTH-1:0] gf;
    logic [WIDTH-1:0] cy;
    logic             unused_pf;

    assign gf        = g_s[LVL];
    assign cy        = {gf[WIDTH-2:0], c_s[LVL]};
    assign unused_pf = ^p_s[LVL];

    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad || !v_s[LVL]) begin
            sum_Pad  <= '0;
            cout_Pad <= 1'b0;
            ovf_Pad  <= 1'b0;
            ovld_Pad <= 1'b0;
        end else begin
            sum_Pad  <= x_s[LVL] ^ cy;
            cout_Pad <= gf[WIDTH-1];
            ovf_Pad  <= gf[WIDTH-2] ^ gf[WIDTH-1];
            ovld_Pad <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ksa_pipe_addsub.sv
// Directed and streaming checks of ksa_pipe_addsub at WIDTH 4, 5 and 8
// with a cycle-accurate arithmetic scoreboard.
module tb_ksa_pipe_addsub;

    logic       clk;
    logic       rst;
    logic       cin;
    logic       sub;
    logic       vld;
    logic [3:0] a4, b4, sum4;
    logic [4:0] a5, b5, sum5;
    logic [7:0] a8, b8, sum8;
    logic       cout4, ovf4, ovld4;
    logic       cout5, ovf5, ovld5;
    logic       cout8, ovf8, ovld8;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ksa_pipe_addsub #(.WIDTH(4)) d4 (
        .GCLK_Pad(clk), .rst_Pad(rst), .a_Pad(a4), .b_Pad(b4),
        .cin_Pad(cin), .sub_Pad(sub), .vld_Pad(vld),
        .sum_Pad(sum4), .cout_Pad(cout4), .ovf_Pad(ovf4), .ovld_Pad(ovld4)
    );

    ksa_pipe_addsub #(.WIDTH(5)) d5 (
        .GCLK_Pad(clk), .rst_Pad(rst), .a_Pad(a5), .b_Pad(b5),
        .cin_Pad(cin), .sub_Pad(sub), .vld_Pad(vld),
        .sum_Pad(sum5), .cout_Pad(cout5), .ovf_Pad(ovf5), .ovld_Pad(ovld5)
    );

    ksa_pipe_addsub #(.WIDTH(8)) d8 (
        .GCLK_Pad(clk), .rst_Pad(rst), .a_Pad(a8), .b_Pad(b8),
        .cin_Pad(cin), .sub_Pad(sub), .vld_Pad(vld),
        .sum_Pad(sum8), .cout_Pad(cout8), .ovf_Pad(ovf8), .ovld_Pad(ovld8)
    );

    // Result word layout: {ovld, cout, ovf, sum[15:0]}.
    logic [18:0] got [3];
    assign got[0] = {ovld4, cout4, ovf4, 12'b0, sum4};
    assign got[1] = {ovld5, cout5, ovf5, 11'b0, sum5};
    assign got[2] = {ovld8, cout8, ovf8, 8'b0, sum8};

    int          wd  [3] = '{4, 5, 8};
    int          lat [3] = '{4, 5, 5};
    logic [18:0] pipe [3][8];
    logic [18:0] expo [3];

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [18:0] exp;
    } vec_t;

    vec_t q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic c, input logic s,
                                          input int w);
        logic [16:0] m, m1, aa, bb, full, low;
        logic        ci, co, cm;
        m    = (17'd1 << w) - 17'd1;
        m1   = (17'd1 << (w - 1)) - 17'd1;
        aa   = {1'b0, a} & m;
        bb   = (s ? ~{1'b0, b} : {1'b0, b}) & m;
        ci   = s ? 1'b1 : c;
        full = aa + bb + {16'b0, ci};
        low  = (aa & m1) + (bb & m1) + {16'b0, ci};
        co   = full[w];
        cm   = low[w-1];
        return {1'b1, co, co ^ cm, full[15:0] & m[15:0]};
    endfunction

    function automatic logic [18:0] e(input logic c, input logic o,
                                      input logic [15:0] s);
        return {1'b1, c, o, s};
    endfunction

    function automatic logic [15:0] op(input int d);
        case (d)
            0:       return {12'b0, a4};
            1:       return {11'b0, a5};
            default: return {8'b0, a8};
        endcase
    endfunction

    function automatic logic [15:0] opb(input int d);
        case (d)
            0:       return {12'b0, b4};
            1:       return {11'b0, b5};
            default: return {8'b0, b8};
        endcase
    endfunction

    task automatic set_ops(input int d, input logic [15:0] a,
                           input logic [15:0] b);
        case (d)
            0:       begin a4 = a[3:0]; b4 = b[3:0]; end
            1:       begin a5 = a[4:0]; b5 = b[4:0]; end
            default: begin a8 = a[7:0]; b8 = b[7:0]; end
        endcase
    endtask

    task automatic rand_ops();
        for (int d = 0; d < 3; d++)
            set_ops(d, 16'($urandom), 16'($urandom));
    endtask

    // One clock edge: advance the scoreboard, then compare every DUT.
    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                for (int k = 0; k < 8; k++) pipe[d][k] = '0;
                expo[d] = '0;
            end else begin
                expo[d] = pipe[d][lat[d]-1];
                for (int k = 7; k > 0; k--) pipe[d][k] = pipe[d][k-1];
                pipe[d][0] = vld ? model(op(d), opb(d), cin, sub, wd[d]) : '0;
            end
        end
        #1;
        for (int d = 0; d < 3; d++)
            check($sformatf("sb_w%0d", wd[d]), 32'(got[d]), 32'(expo[d]));
    endtask

    task automatic add(input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic c,
                       input logic s, input logic [18:0] x);
        vec_t t;
        t.v = v; t.a = a; t.b = b; t.cin = c; t.sub = s; t.exp = x;
        q.push_back(t);
    endtask

    // Stream the queued vectors into DUT d and check each result LAT edges later.
    task automatic play(input string tag, input int d);
        int n;
        n = q.size();
        for (int i = 0; i < n + lat[d]; i++) begin
            rand_ops();
            if (i < n) begin
                vld = q[i].v;
                cin = q[i].cin;
                sub = q[i].sub;
                set_ops(d, q[i].a, q[i].b);
            end else begin
                vld = 1'b0;
            end
            step();
            if (i >= lat[d])
                check($sformatf("%s_%0d", tag, i - lat[d]), 32'(got[d]),
                      32'(q[i-lat[d]].exp));
        end
        q.delete();
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; cin = 1'b0; sub = 1'b0;
        a4 = '0; b4 = '0; a5 = '0; b5 = '0; a8 = '0; b8 = '0;
        for (int d = 0; d < 3; d++) begin
            expo[d] = '0;
            for (int k = 0; k < 8; k++) pipe[d][k] = '0;
        end
        step();
        step();
        check("rst_w4", 32'(got[0]), 32'h0);
        check("rst_w8", 32'(got[2]), 32'h0);
        rst = 1'b0;
        step();

        add(1, 16'hF, 16'h1, 0, 0, e(1, 0, 16'h0));
        add(0, 16'h0, 16'h0, 0, 0, 19'h0);
        play("wrap", 0);

        add(1, 16'h7, 16'h1, 0, 0, e(0, 1, 16'h8));
        add(1, 16'h3, 16'h5, 1, 0, e(0, 1, 16'h9));
        play("sovf", 0);

        add(1, 16'h3, 16'h5, 1, 1, e(0, 0, 16'hE));
        add(1, 16'h5, 16'h3, 0, 1, e(1, 0, 16'h2));
        play("sub", 0);

        add(1, 16'h1, 16'h1, 0, 0, e(0, 0, 16'h2));
        add(1, 16'h2, 16'h2, 0, 0, e(0, 0, 16'h4));
        add(1, 16'h6, 16'h3, 0, 0, e(0, 1, 16'h9));
        add(1, 16'hF, 16'hF, 0, 0, e(1, 0, 16'hE));
        add(0, 16'h0, 16'h0, 0, 0, 19'h0);
        play("strm", 0);

        add(1, 16'h1, 16'h2, 0, 0, e(0, 0, 16'h3));
        add(0, 16'h5, 16'h5, 0, 0, 19'h0);
        add(1, 16'h4, 16'h4, 0, 0, e(0, 1, 16'h8));
        play("gap", 0);

        // Reset two edges after two valid pairs, then a fresh pair.
        vld = 1'b1; a4 = 4'h1; b4 = 4'h1; step();
        a4 = 4'h2; b4 = 4'h2; step();
        vld = 1'b0; rst = 1'b1; step();
        check("rmid_rst", 32'(got[0]), 32'h0);
        rst = 1'b0; vld = 1'b1; cin = 1'b0; sub = 1'b0;
        a4 = 4'h3; b4 = 4'h4; step();
        vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rmid_idle", 32'(ovld4), 32'h0);
        end
        step();
        check("rmid_res", 32'(got[0]), 32'(e(0, 0, 16'h7)));

        // Reset and valid on the same edge: operand dropped.
        rst = 1'b1; vld = 1'b1; a4 = 4'h5; b4 = 4'h5; step();
        rst = 1'b0; vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_vld", 32'(ovld4), 32'h0);
        end

        add(1, 16'hFF, 16'h01, 1, 0, e(1, 0, 16'h01));
        add(1, 16'h80, 16'h01, 0, 1, e(1, 1, 16'h7F));
        add(0, 16'h00, 16'h00, 0, 0, 19'h0);
        play("w8", 2);

        add(1, 16'h0F, 16'h01, 0, 0, e(0, 1, 16'h10));
        add(1, 16'h1F, 16'h01, 0, 0, e(1, 0, 16'h00));
        add(1, 16'h10, 16'h01, 0, 1, e(1, 1, 16'h0F));
        play("w5", 1);

        for (int i = 0; i < 400; i++) begin
            rand_ops();
            vld = 1'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0; vld = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
